// File: rtl/store_byte_writer.sv
// store_byte_writer: aligns CPU byte/halfword/word stores onto byte lanes,
// buffers them in a small merging FIFO and drains one masked word write per
// cycle into the byte-masked word memory port.
module store_byte_writer #(
  parameter int lines   = 16,
  parameter int setbits = $clog2(lines),
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               StoreValid,
  input  logic [setbits+1:0] StoreAddr,
  input  logic [1:0]         StoreSize,
  input  logic [31:0]        StoreData,
  output logic               StoreReady,
  output logic               MisalignedFault,
  input  logic               MemBusy,
  output logic               we,
  output logic [setbits-1:0] set,
  output logic [3:0]         ByteMask,
  output logic [31:0]        wd,
  output logic               Empty
);

  localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);

  logic [PW-1:0]                 head, tail, newest;
  logic [PW:0]                   count;
  logic [DEPTH-1:0][setbits-1:0] ent_set;
  logic [DEPTH-1:0][3:0]         ent_mask;
  logic [DEPTH-1:0][31:0]        ent_data;

  logic [setbits-1:0] st_set;
  logic [1:0]         st_off;
  logic [3:0]         st_mask;
  logic [31:0]        st_data;
  logic               st_mis;
  logic               nonempty, take, merge, enq, fault_q;
  logic [31:0]        merged;

  assign st_set = StoreAddr[setbits+1:2];
  assign st_off = StoreAddr[1:0];

  // Lane placement, byte enables and misalignment detection for the offered store
  always_comb begin
    st_mask = '0;
    st_data = '0;
    st_mis  = 1'b0;
    case (StoreSize)
      2'b00: begin
        st_mask = 4'b0001 << st_off;
        st_data = {4{StoreData[7:0]}};
      end
      2'b01: begin
        st_mis  = st_off[0];
        st_mask = st_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{StoreData[15:0]}};
      end
      2'b10: begin
        st_mis  = (st_off != 2'b00);
        st_mask = 4'b1111;
        st_data = StoreData;
      end
      default: st_mis = 1'b1;
    endcase
  end

  assign nonempty   = (count != '0);
  assign we         = nonempty & ~MemBusy;
  assign StoreReady = (count != FULL);
  assign Empty      = ~nonempty;
  assign take       = StoreValid & StoreReady;
  assign newest     = tail - PW'(1);

  // The newest entry is the head only when count==1; never merge into an entry leaving this cycle.
  assign merge = take & ~st_mis & nonempty & (ent_set[newest] == st_set)
               & ~((count == ONE) & we);
  assign enq   = take & ~st_mis & ~merge;

  // Newer store wins on every lane it enables; other lanes keep the buffered bytes
  genvar l;
  generate
    for (l = 0; l < 4; l++) begin : g_lane
      assign merged[8*l +: 8] = st_mask[l] ? st_data[8*l +: 8] : ent_data[newest][8*l +: 8];
    end
  endgenerate

  assign set             = nonempty ? ent_set[head]  : '0;
  assign ByteMask        = nonempty ? ent_mask[head] : '0;
  assign wd              = nonempty ? ent_data[head] : '0;
  assign MisalignedFault = fault_q;

  // Buffer state: pointers, occupancy, entry payloads and the fault pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ent_set  <= '0;
      ent_mask <= '0;
      ent_data <= '0;
      fault_q  <= 1'b0;
    end else begin
      fault_q <= take & st_mis;
      if (we) head <= head + PW'(1);
      if (enq) begin
        ent_set[tail]  <= st_set;
        ent_mask[tail] <= st_mask;
        ent_data[tail] <= st_data;
        tail           <= tail + PW'(1);
      end
      if (merge) begin
        ent_mask[newest] <= ent_mask[newest] | st_mask;
        ent_data[newest] <= merged;
      end
      case ({enq, we})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_byte_writer.sv
// Bench for store_byte_writer: queue-based reference model of the store
// buffer, checked against every output on every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_store_byte_writer;
  localparam int LINES = 16;
  localparam int SB    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          StoreValid;
  logic [SB+1:0] StoreAddr;
  logic [1:0]    StoreSize;
  logic [31:0]   StoreData;
  logic          StoreReady, MisalignedFault, MemBusy, we, Empty;
  logic [SB-1:0] set;
  logic [3:0]    ByteMask;
  logic [31:0]   wd;

  always #5 clk = ~clk;

  store_byte_writer #(.lines(LINES), .setbits(SB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .StoreValid(StoreValid), .StoreAddr(StoreAddr),
    .StoreSize(StoreSize), .StoreData(StoreData), .StoreReady(StoreReady),
    .MisalignedFault(MisalignedFault), .MemBusy(MemBusy), .we(we), .set(set),
    .ByteMask(ByteMask), .wd(wd), .Empty(Empty)
  );

  typedef struct {
    logic [SB-1:0] s;
    logic [3:0]    m;
    logic [31:0]   d;
  } ent_t;

  ent_t        q[$];
  logic        exp_fault;
  int          passed, total;
  logic [31:0] ref_mem[LINES];
  logic [31:0] dut_mem[LINES];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Store of 2^sz bytes at offset o covers lanes o..o+n-1; the data pattern repeats every n lanes.
  task automatic align(input logic [1:0] sz, input logic [1:0] o, input logic [31:0] d,
                       output logic [3:0] m, output logic [31:0] w, output bit mis);
    int n;
    n   = 1 << sz;
    mis = (sz == 2'd3) || ((int'(o) % n) != 0);
    m   = '0;
    w   = '0;
    if (!mis)
      for (int L = 0; L < 4; L++) begin
        w[8*L +: 8] = d[8*(L % n) +: 8];
        m[L]        = (L >= int'(o)) && (L < int'(o) + n);
      end
  endtask

  task automatic apply(inout logic [31:0] word, input logic [3:0] m, input logic [31:0] d);
    for (int L = 0; L < 4; L++) if (m[L]) word[8*L +: 8] = d[8*L +: 8];
  endtask

  // Drive one cycle's inputs, compare all outputs with the model, then advance the model.
  task automatic drive_chk(input logic v, input logic [SB-1:0] s, input logic [1:0] o,
                           input logic [1:0] sz, input logic [31:0] d, input logic busy);
    logic [3:0]    m, em;
    logic [31:0]   w, ed;
    logic [SB-1:0] es;
    bit            mis, acc, ew;
    ent_t          e;
    StoreValid = v; StoreAddr = {s, o}; StoreSize = sz; StoreData = d; MemBusy = busy;
    #1;
    ew = (q.size() != 0) && !busy;
    es = (q.size() != 0) ? q[0].s : '0;
    em = (q.size() != 0) ? q[0].m : '0;
    ed = (q.size() != 0) ? q[0].d : '0;
    chk("we", we, ew);
    chk("Empty", Empty, q.size() == 0);
    chk("StoreReady", StoreReady, q.size() != DEPTH);
    chk("MisalignedFault", MisalignedFault, exp_fault);
    chk("set", set, es);
    chk("ByteMask", ByteMask, em);
    chk("wd", wd, ed);
    if (we) apply(dut_mem[set], ByteMask, wd);
    acc = v && (q.size() != DEPTH);
    align(sz, o, d, m, w, mis);
    if (ew) apply(ref_mem[q[0].s], q[0].m, q[0].d);
    if (acc && !mis) begin
      if (q.size() >= 1 && q[q.size()-1].s == s && !(q.size() == 1 && ew)) begin
        e = q[q.size()-1];
        for (int L = 0; L < 4; L++) if (m[L]) e.d[8*L +: 8] = w[8*L +: 8];
        e.m = e.m | m;
        q[q.size()-1] = e;
      end else begin
        e.s = s; e.m = m; e.d = w;
        q.push_back(e);
      end
    end
    if (ew) void'(q.pop_front());
    exp_fault = acc && mis;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic busy);
    drive_chk(1'b0, '0, 2'd0, 2'd0, 32'h0, busy);
  endtask

  initial begin
    passed = 0; total = 0; exp_fault = 1'b0;
    for (int i = 0; i < LINES; i++) begin ref_mem[i] = '0; dut_mem[i] = '0; end
    reset_n = 1'b0; StoreValid = 1'b0; StoreAddr = '0; StoreSize = '0; StoreData = '0; MemBusy = 1'b0;
    #2;
    chk("rst_we", we, 0);
    chk("rst_Empty", Empty, 1);
    chk("rst_StoreReady", StoreReady, 1);
    chk("rst_ByteMask", ByteMask, 0);
    chk("rst_wd", wd, 0);
    chk("rst_fault", MisalignedFault, 0);
    @(posedge clk); tick();
    reset_n = 1'b1;

    // Single byte store to set 3, offset 2
    drive_chk(1'b1, 4'd3, 2'd2, 2'd0, 32'h0000_00AB, 1'b0); tick();
    idle(1'b0);
    chk("t1_we", we, 1);
    chk("t1_set", set, 3);
    chk("t1_mask", ByteMask, 4'b0100);
    chk("t1_lane2", wd[23:16], 8'hAB);
    tick();
    idle(1'b0);
    chk("t1_empty", Empty, 1);
    tick();

    // Merge under stall: halfword then byte into set 5
    drive_chk(1'b1, 4'd5, 2'd0, 2'd1, 32'h0000_1234, 1'b1); tick();
    drive_chk(1'b1, 4'd5, 2'd0, 2'd0, 32'h0000_0056, 1'b1); tick();
    idle(1'b1);
    chk("t2_model_count", q.size(), 1);
    chk("t2_notempty", Empty, 0);
    tick();
    idle(1'b0);
    chk("t2_we", we, 1);
    chk("t2_mask", ByteMask, 4'b0011);
    chk("t2_lo", wd[15:0], 16'h1256);
    tick();
    idle(1'b0);
    chk("t2_single_write", we, 0);
    tick();

    // Fill under stall, hold a fifth store, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive_chk(1'b1, SB'(i), 2'd0, 2'd2, 32'h1000 + i, 1'b1); tick();
    end
    drive_chk(1'b1, 4'd4, 2'd0, 2'd2, 32'h1004, 1'b1);
    chk("t3_full", StoreReady, 0);
    tick();
    drive_chk(1'b1, 4'd4, 2'd0, 2'd2, 32'h1004, 1'b0);
    chk("t3_first_set", set, 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      if (i == 1) drive_chk(1'b1, 4'd4, 2'd0, 2'd2, 32'h1004, 1'b0);
      else        idle(1'b0);
      chk("t3_order_we", we, 1);
      chk("t3_order_set", set, i);
      tick();
    end
    idle(1'b0);
    chk("t3_done", Empty, 1);
    tick();

    // No merge into a head that is draining this cycle
    drive_chk(1'b1, 4'd7, 2'd0, 2'd0, 32'h11, 1'b0); tick();
    drive_chk(1'b1, 4'd7, 2'd1, 2'd0, 32'h22, 1'b0);
    chk("t4_first_mask", ByteMask, 4'b0001);
    tick();
    idle(1'b0);
    chk("t4_second_we", we, 1);
    chk("t4_second_set", set, 7);
    chk("t4_second_mask", ByteMask, 4'b0010);
    tick();

    // Misaligned word at o=2, then halfword at o=3
    drive_chk(1'b1, 4'd2, 2'd2, 2'd2, 32'hDEAD_BEEF, 1'b0); tick();
    idle(1'b0);
    chk("t5_fault_w", MisalignedFault, 1);
    chk("t5_empty_w", Empty, 1);
    tick();
    drive_chk(1'b1, 4'd2, 2'd3, 2'd1, 32'hBEEF, 1'b0);
    chk("t5_fault_low", MisalignedFault, 0);
    tick();
    idle(1'b0);
    chk("t5_fault_h", MisalignedFault, 1);
    chk("t5_empty_h", Empty, 1);
    tick();

    // Randomized traffic over a few sets to exercise merging, stalls and faults
    for (int c = 0; c < 600; c++) begin
      drive_chk($urandom_range(0, 3) != 0, SB'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                $urandom, $urandom_range(0, 2) == 0);
      tick();
    end
    for (int i = 0; i < DEPTH + 4 && q.size() != 0; i++) begin idle(1'b0); tick(); end
    idle(1'b0);
    chk("rand_drained", Empty, 1);
    tick();
    for (int i = 0; i < LINES; i++) chk("mem", dut_mem[i], ref_mem[i]);

    // Asynchronous reset with three entries buffered, mid-drain
    drive_chk(1'b1, 4'd8, 2'd0, 2'd2, 32'hA8, 1'b1); tick();
    drive_chk(1'b1, 4'd9, 2'd0, 2'd2, 32'hA9, 1'b1); tick();
    drive_chk(1'b1, 4'd10, 2'd0, 2'd2, 32'hAA, 1'b1); tick();
    StoreValid = 1'b0; MemBusy = 1'b0;
    #1;
    chk("t6_pre_we", we, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_we", we, 0);
    chk("t6_empty", Empty, 1);
    chk("t6_mask", ByteMask, 0);
    q.delete();
    exp_fault = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("t6_no_write", we, 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/store_byte_writer.md
# store_byte_writer

Store-side initiator for the byte-masked word memory port. Accepts CPU byte, halfword and word stores and aligns them onto byte lanes with a matching byte mask. Buffers them in a small merging FIFO and drains at most one masked word write per cycle into the word memory's `we`/`set`/`ByteMask`/`wd` port. It sits between the pipeline's memory stage and the cache data array, and decouples store issue from array port contention.

## Interface
Parameters:
- `lines`, 16: word-memory depth, in words.
- `setbits`, `$clog2(lines)`: word-index width.
- `DEPTH`, 4: store-buffer entries (power of two, ≥2).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `StoreValid`  in  1  store request this cycle.
- `StoreAddr`  in  setbits+2  byte address: `[setbits+1:2]` is the word index, `[1:0]` is the byte offset.
- `StoreSize`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `StoreData`  in  32  right-justified store data.
- `StoreReady`  out  1  buffer can accept; a store is taken when `StoreValid & StoreReady`.
- `MisalignedFault`  out  1  one-cycle pulse: the previous cycle's offered store was rejected.
- `MemBusy`  in  1  memory port is owned by another user this cycle; no drain.
- `we`  out  1  memory write enable.
- `set`  out  setbits  memory word index.
- `ByteMask`  out  4  memory byte enables.
- `wd`  out  32  memory write data, lane-aligned.
- `Empty`  out  1  no buffered stores.

## Operation
- Alignment and masking, with offset o = `StoreAddr[1:0]`:
  - Byte: mask = 1<<o; `StoreData[7:0]` is replicated on all lanes.
  - Halfword: o=0 gives mask 0011; o=2 gives mask 1100. `StoreData[15:0]` is placed on lanes {1,0} or {3,2}.
  - Word: o=0 gives mask 1111.
  - Misaligned means a halfword at o∈{1,3}, a word at o≠0, or size 11. A misaligned store is consumed, not enqueued, and raises `MisalignedFault` the next cycle.
- FIFO state: entries hold {set, mask[3:0], data[31:0]}; head/tail pointers wrap modulo `DEPTH`; `count` ranges 0..`DEPTH`.
- `StoreReady = (count != DEPTH)`. This is registered-state only, with no same-cycle fall-through from a drain.
- Merge: an accepted, aligned store merges into the newest entry, not a new one, when all of the following hold:
  - `count ≥ 1`;
  - the newest entry's set equals the store's word index;
  - the newest entry is not the head being drained this cycle. When `count==1` and `we==1`, do not merge; enqueue a new entry.
- Merge update: entry mask |= new mask. For each lane set in the new mask, entry data lane = new data lane, so the newer store wins. `count` is unchanged.
- Otherwise an aligned accepted store writes the tail entry and increments `count`.
- Drain:
  - `we = (count != 0) & !MemBusy`.
  - `set`, `ByteMask` and `wd` come from the head entry and are combinational from registers.
  - When `we`, the head pops at the clock edge.
  - When `count==0`, `set`, `ByteMask` and `wd` drive 0.
- Simultaneous accept (new entry) and drain: `count` is unchanged and both pointers advance.
- `Empty = (count == 0)`.

## Timing
- Reset, asynchronous while `reset_n` is 0:
  - `count`, pointers and all entry fields are 0.
  - Outputs: `we`=0, `ByteMask`=0, `wd`=0, `set`=0, `Empty`=1, `StoreReady`=1, `MisalignedFault`=0.
- Reset asserted mid-drain or mid-accept discards all buffered stores immediately.
- Latency: a store accepted in cycle N is visible at the head, with `we`=1, in cycle N+1 if the buffer was empty and `MemBusy`=0. The memory array updates at the end of N+1.
- `MemBusy` stalls drain indefinitely. Entries keep accepting and merging until full.
- `MisalignedFault` is registered: high exactly for cycle N+1 after the offending store in N, and low otherwise. A store with `StoreReady`=0 is not consumed and raises no fault.
- Throughput: one accept and one drain per cycle.

## Test plan
- Reset then single store: byte at addr {set 3, o=2}, data 0xAB, `MemBusy`=0. Next cycle expect `we`=1, `set`=3, `ByteMask`=0100, `wd[23:16]`=0xAB; then `Empty`=1.
- Merge under stall: with `MemBusy`=1, store a halfword at set 5 o=0 with data 0x1234, then a byte at set 5 o=0 with data 0x56. Expect `count`=1. Release `MemBusy` and expect one write: `ByteMask`=0011, `wd[15:0]`=0x1256.
- Full and backpressure: with `MemBusy`=1, store words to sets 0,1,2,3. Expect `StoreReady`=0. Offer a fifth store to set 4 and expect it is held, not lost. Release and expect four writes in order 0,1,2,3, then set 4.
- No-merge with draining head: with `count`=1 (set 7) draining this cycle, store a byte to set 7. Expect two separate writes to set 7 in consecutive cycles.
- Misaligned: word at o=2. Expect `MisalignedFault`=1 for one cycle, no enqueue, and `Empty` stays 1. Halfword at o=3 gives the same result.
- Async reset with 3 entries buffered: pull `reset_n` low mid-cycle. Expect `we`=0 and `Empty`=1 immediately, and no writes after release.
